// File: rtl/step_counter_taps.sv
// step_counter_taps: parametrised step counter with decoded tap strobes,
// terminal count, wrap pulse and sticky overflow for the AXBY control path.
// Optional down-count port is enabled by defining STEP_COUNTER_DEC_EN.
// Ports: clk, reset (async, active-low), inc, clr, load, load_val[WIDTH],
//   dec (STEP_COUNTER_DEC_EN only), count[WIDTH], tap[NUM_TAPS], tc,
//   wrap (registered pulse on TERM->0 or 0->TERM), ovf (sticky, saturate).
module step_counter_taps #(
   parameter int                        WIDTH      = 3,
   parameter int                        TERM       = (1 << WIDTH) - 1,
   parameter int                        NUM_TAPS   = 3,
   parameter logic [NUM_TAPS*WIDTH-1:0] TAP_VALUES = {3'd7, 3'd6, 3'd2},
   parameter bit                        SATURATE   = 1'b0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                inc,
   input  logic                clr,
   input  logic                load,
   input  logic [WIDTH-1:0]    load_val,
`ifdef STEP_COUNTER_DEC_EN
   input  logic                dec,
`endif
   output logic [WIDTH-1:0]    count,
   output logic [NUM_TAPS-1:0] tap,
   output logic                tc,
   output logic                wrap,
   output logic                ovf
);

   generate
      if (TERM > (1 << WIDTH) - 1 || TERM < 0) begin : g_bad_term
         $fatal(1, "step_counter_taps: TERM does not fit in WIDTH");
      end
      if (NUM_TAPS == 0) begin : g_bad_taps
         $fatal(1, "step_counter_taps: NUM_TAPS must be at least 1");
      end
   endgenerate

   localparam logic [WIDTH-1:0] TERM_V = WIDTH'(TERM);
   localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_n;
   logic             wrap_q;
   logic             wrap_n;
   logic             ovf_q;
   logic             ovf_n;
   logic             at_term;

   assign at_term = (count_q == TERM_V);

   // One action per cycle, highest priority first; wrap defaults low so
   // it can only ever last a single cycle.
   always_comb begin
      count_n = count_q;
      wrap_n  = 1'b0;
      ovf_n   = ovf_q;
      if (clr) begin
         count_n = '0;
         ovf_n   = 1'b0;
      end else if (load) begin
         count_n = (load_val > TERM_V) ? TERM_V : load_val;
`ifdef STEP_COUNTER_DEC_EN
      end else if (inc && dec) begin
         count_n = count_q;
`endif
      end else if (inc) begin
         if (!at_term) begin
            count_n = count_q + ONE;
         end else if (SATURATE) begin
            ovf_n = 1'b1;
         end else begin
            count_n = '0;
            wrap_n  = 1'b1;
         end
`ifdef STEP_COUNTER_DEC_EN
      end else if (dec) begin
         if (count_q != '0) begin
            count_n = count_q - ONE;
         end else if (SATURATE) begin
            ovf_n = 1'b1;
         end else begin
            count_n = TERM_V;
            wrap_n  = 1'b1;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_n;
         wrap_q  <= wrap_n;
         ovf_q   <= ovf_n;
      end
   end

   // Taps above TERM can never match because count never exceeds TERM.
   generate
      for (genvar i = 0; i < NUM_TAPS; i++) begin : g_tap
         assign tap[i] = (count_q == TAP_VALUES[i*WIDTH +: WIDTH]);
      end
   endgenerate

   assign count = count_q;
   assign tc    = at_term;
   assign wrap  = wrap_q;
   assign ovf   = ovf_q;

endmodule

// File: tb/tb_step_counter_taps.sv
// tb_step_counter_taps: three configurations of step_counter_taps checked
// against directed vectors and a behavioural model under random stimulus.
module tb_step_counter_taps;

   localparam int N = 3;
`ifdef STEP_COUNTER_DEC_EN
   localparam bit DEC_EN = 1'b1;
`else
   localparam bit DEC_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset, inc, clr, load, dec;
   logic [7:0] lv;

   logic [2:0] cnt0, cnt1, tap0, tap1;
   logic [7:0] cnt2;
   logic [1:0] tap2;
   logic       tc0, tc1, tc2, wrap0, wrap1, wrap2, ovf0, ovf1, ovf2;

   always #5 clk = ~clk;

   step_counter_taps u0 (
      .clk(clk), .reset(reset), .inc(inc), .clr(clr), .load(load),
      .load_val(lv[2:0]),
`ifdef STEP_COUNTER_DEC_EN
      .dec(dec),
`endif
      .count(cnt0), .tap(tap0), .tc(tc0), .wrap(wrap0), .ovf(ovf0)
   );

   step_counter_taps #(.TERM(5), .SATURATE(1'b1)) u1 (
      .clk(clk), .reset(reset), .inc(inc), .clr(clr), .load(load),
      .load_val(lv[2:0]),
`ifdef STEP_COUNTER_DEC_EN
      .dec(dec),
`endif
      .count(cnt1), .tap(tap1), .tc(tc1), .wrap(wrap1), .ovf(ovf1)
   );

   step_counter_taps #(
      .WIDTH(8), .TERM(200), .NUM_TAPS(2),
      .TAP_VALUES({8'd250, 8'd100})
   ) u2 (
      .clk(clk), .reset(reset), .inc(inc), .clr(clr), .load(load),
      .load_val(lv),
`ifdef STEP_COUNTER_DEC_EN
      .dec(dec),
`endif
      .count(cnt2), .tap(tap2), .tc(tc2), .wrap(wrap2), .ovf(ovf2)
   );

   int term[N]   = '{7, 5, 200};
   bit sat[N]    = '{1'b0, 1'b1, 1'b0};
   int wd[N]     = '{3, 3, 8};
   int ntap[N]   = '{3, 3, 2};
   int tv[N][3]  = '{'{2, 6, 7}, '{2, 6, 7}, '{100, 250, 0}};

   int m_cnt[N];
   bit m_wrap[N];
   bit m_ovf[N];

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < N; k++) begin
         m_cnt[k] = 0; m_wrap[k] = 0; m_ovf[k] = 0;
      end
   endtask

   task automatic model_step();
      int v;
      for (int k = 0; k < N; k++) begin
         if (clr) begin
            m_cnt[k] = 0; m_ovf[k] = 0; m_wrap[k] = 0;
         end else if (load) begin
            v = int'(lv) % (1 << wd[k]);
            m_cnt[k] = (v > term[k]) ? term[k] : v;
            m_wrap[k] = 0;
         end else if (DEC_EN && inc && dec) begin
            m_wrap[k] = 0;
         end else if (inc) begin
            m_wrap[k] = 0;
            if (m_cnt[k] < term[k]) m_cnt[k]++;
            else if (sat[k]) m_ovf[k] = 1;
            else begin m_cnt[k] = 0; m_wrap[k] = 1; end
         end else if (DEC_EN && dec) begin
            m_wrap[k] = 0;
            if (m_cnt[k] > 0) m_cnt[k]--;
            else if (sat[k]) m_ovf[k] = 1;
            else begin m_cnt[k] = term[k]; m_wrap[k] = 1; end
         end else begin
            m_wrap[k] = 0;
         end
      end
   endtask

   task automatic check_all(input string tag);
      int ac[N], at[N], atc[N], aw[N], ao[N];
      int et;
      ac  = '{int'(cnt0), int'(cnt1), int'(cnt2)};
      at  = '{int'(tap0), int'(tap1), int'(tap2)};
      atc = '{int'(tc0), int'(tc1), int'(tc2)};
      aw  = '{int'(wrap0), int'(wrap1), int'(wrap2)};
      ao  = '{int'(ovf0), int'(ovf1), int'(ovf2)};
      for (int k = 0; k < N; k++) begin
         et = 0;
         for (int i = 0; i < ntap[k]; i++)
            if (m_cnt[k] == tv[k][i]) et |= (1 << i);
         chk($sformatf("%s u%0d count", tag, k), ac[k], m_cnt[k]);
         chk($sformatf("%s u%0d tap", tag, k), at[k], et);
         chk($sformatf("%s u%0d tc", tag, k), atc[k],
             int'(m_cnt[k] == term[k]));
         chk($sformatf("%s u%0d wrap", tag, k), aw[k], int'(m_wrap[k]));
         chk($sformatf("%s u%0d ovf", tag, k), ao[k], int'(m_ovf[k]));
      end
   endtask

   task automatic cycle(input bit i, input bit c, input bit l,
                        input int v, input bit d);
      inc = i; clr = c; load = l; lv = 8'(v); dec = d;
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   typedef struct {
      bit inc; bit clr; bit load; int lv;
      int e0; bit w0; int e1; bit o1;
   } vec_t;

   vec_t tbl[14];
   int   p_t0, p_t1, p_w;
   int   et0;

   initial begin
      tbl = '{
         '{1, 0, 0, 0, 1, 0, 1, 0},
         '{1, 0, 0, 0, 2, 0, 2, 0},
         '{1, 0, 0, 0, 3, 0, 3, 0},
         '{1, 0, 0, 0, 4, 0, 4, 0},
         '{1, 0, 0, 0, 5, 0, 5, 0},
         '{1, 0, 0, 0, 6, 0, 5, 1},
         '{1, 0, 0, 0, 7, 0, 5, 1},
         '{1, 0, 0, 0, 0, 1, 5, 1},
         '{0, 0, 0, 0, 0, 0, 5, 1},
         '{0, 1, 0, 0, 0, 0, 0, 0},
         '{1, 1, 1, 4, 0, 0, 0, 0},
         '{1, 0, 1, 4, 4, 0, 4, 0},
         '{0, 0, 1, 7, 7, 0, 5, 0},
         '{1, 0, 0, 0, 0, 1, 5, 1}
      };

      reset = 1'b0; inc = 0; clr = 0; load = 0; dec = 0; lv = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all("reset");
      reset = 1'b1;

      for (int n = 0; n < 14; n++) begin
         cycle(tbl[n].inc, tbl[n].clr, tbl[n].load, tbl[n].lv, 1'b0);
         check_all($sformatf("vec%0d", n));
         et0 = int'(tbl[n].e0 == 2) | (int'(tbl[n].e0 == 6) << 1)
             | (int'(tbl[n].e0 == 7) << 2);
         chk($sformatf("vec%0d count0", n), int'(cnt0), tbl[n].e0);
         chk($sformatf("vec%0d tap0", n), int'(tap0), et0);
         chk($sformatf("vec%0d tc0", n), int'(tc0), int'(tbl[n].e0 == 7));
         chk($sformatf("vec%0d wrap0", n), int'(wrap0), int'(tbl[n].w0));
         chk($sformatf("vec%0d count1", n), int'(cnt1), tbl[n].e1);
         chk($sformatf("vec%0d ovf1", n), int'(ovf1), int'(tbl[n].o1));
      end

      cycle(0, 0, 1, 6, 0);
      check_all("preload6");
      #2 reset = 1'b0;
      model_reset();
      #1 check_all("async");
      chk("async count0", int'(cnt0), 0);
      #1 reset = 1'b1;
      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      check_all("post_reset");
      chk("post_reset count0", int'(cnt0), 2);
      chk("post_reset tap0[0]", int'(tap0[0]), 1);

      cycle(0, 1, 0, 0, 0);
      p_t0 = 0; p_t1 = 0; p_w = 0;
      for (int n = 0; n < 201; n++) begin
         cycle(1, 0, 0, 0, 0);
         check_all($sformatf("w8_%0d", n));
         p_t0 += int'(tap2[0]);
         p_t1 += int'(tap2[1]);
         p_w  += int'(wrap2);
      end
      chk("w8 tap0 pulses", p_t0, 1);
      chk("w8 tap1 pulses", p_t1, 0);
      chk("w8 wrap pulses", p_w, 1);
      chk("w8 final count", int'(cnt2), 0);

      if (DEC_EN) begin
         cycle(0, 1, 0, 0, 0);
         cycle(0, 0, 0, 0, 1);
         check_all("dec0");
         chk("dec0 count0", int'(cnt0), 7);
         chk("dec0 wrap0", int'(wrap0), 1);
         chk("dec0 count1", int'(cnt1), 0);
         chk("dec0 ovf1", int'(ovf1), 1);
         cycle(1, 0, 0, 0, 1);
         check_all("incdec");
         chk("incdec count0", int'(cnt0), 7);
         chk("incdec wrap0", int'(wrap0), 0);
      end

      for (int n = 0; n < 400; n++) begin
         cycle(($urandom % 4) != 0,
               $urandom_range(0, 19) == 0,
               $urandom_range(0, 14) == 0,
               int'($urandom_range(0, 255)),
               DEC_EN && (($urandom % 3) == 0));
         check_all($sformatf("rnd%0d", n));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
